// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: write-through FIFO between the dcache write port and
// the main-memory write path. It drains one entry at a time whenever no cache
// fill is active, and holds each write on mem_* until memory accepts it.
// Optional feature macro: WB_FORWARD_EN. When it is defined, loads can read
// data from buffered writes whose address matches (store-to-load forwarding).
module dcache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req_valid,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              wr_req_ready,
  input  logic              fill_busy,
  output logic              buf_empty,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_wr,
  input  logic              mem_busy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {IDLE, ISSUE} state_e;

  entry_t             buf_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d, head_nxt;
  logic [CNT_W-1:0]   count_q, count_d;
  state_e             state_q, state_d;
  logic               mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_data_q, mem_data_d;
  logic               push, pop, full;

  assign full         = (count_q == CNT_W'(DEPTH));
  assign wr_req_ready = ~full;
  assign push         = wr_req_valid & wr_req_ready;
  assign head_nxt     = head_q + PTR_W'(1);
  assign buf_empty    = (count_q == '0) && (state_q == IDLE);

  assign mem_wr         = mem_wr_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_data_q;

  // Entry storage: no reset needed, occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) buf_q[tail_q] <= '{addr: wr_req_addr, data: wr_req_data};
  end

  // Drain FSM next state: start a write from IDLE, chain writes back-to-back.
  always_comb begin
    state_d    = state_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0 && !fill_busy) begin
          mem_wr_d   = 1'b1;
          mem_addr_d = buf_q[head_q].addr;
          mem_data_d = buf_q[head_q].data;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!mem_busy) begin
          pop = 1'b1;
          // Only entries already stored count; a same-cycle enqueue waits.
          if (count_q > CNT_W'(1) && !fill_busy) begin
            mem_addr_d = buf_q[head_nxt].addr;
            mem_data_d = buf_q[head_nxt].data;
          end else begin
            mem_wr_d   = 1'b0;
            mem_addr_d = '0;
            mem_data_d = '0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer and occupancy next state.
  always_comb begin
    head_d  = pop  ? head_nxt : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State, pointers and registered memory-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

`ifdef WB_FORWARD_EN
  // Forwarding lookup, oldest to newest so the newest match wins; the
  // in-flight head stays visible until memory accepts it.
  always_comb begin
    logic [PTR_W-1:0] idx;
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q && buf_q[idx].addr == rd_addr) begin
        rd_hit  = 1'b1;
        rd_data = buf_q[idx].data;
      end
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_hit         = 1'b0;
  assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Bench for dcache_write_buffer: directed steps plus a random phase. A queue
// of accepted-but-not-yet-written entries serves as the reference; every
// negedge checks ready/empty/forwarding against it and checks each memory
// write against the queue front.
module tb_dcache_write_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_req_valid = 1'b0;
  logic [15:0] wr_req_addr = '0;
  logic [15:0] wr_req_data = '0;
  logic        wr_req_ready;
  logic        fill_busy = 1'b0;
  logic        buf_empty;
  logic [15:0] mem_addr;
  logic [15:0] mem_write_data;
  logic        mem_wr;
  logic        mem_busy = 1'b0;
  logic [15:0] rd_addr = '0;
  logic        rd_hit;
  logic [15:0] rd_data;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] model_q[$];
  logic [15:0] ent_a[5];
  logic [15:0] ent_d[5];
  logic        acc;

  dcache_write_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data), .wr_req_ready(wr_req_ready),
    .fill_busy(fill_busy), .buf_empty(buf_empty),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_wr(mem_wr),
    .mem_busy(mem_busy), .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int bound);
    int c = 0;
    while (!buf_empty && c < bound) begin
      tick();
      c++;
    end
    chk("drain_done", {31'd0, buf_empty}, 32'd1);
  endtask

  // Reset discards everything held or in flight.
  always @(negedge rst_n) model_q.delete();

  // Reference checks mid-cycle; updates predict what the next posedge does.
  always @(negedge clk) begin
    logic        e_hit;
    logic [15:0] e_data;
    chk("ready", {31'd0, wr_req_ready}, {31'd0, model_q.size() < 4});
    chk("buf_empty", {31'd0, buf_empty}, {31'd0, model_q.size() == 0});
    if (mem_wr) begin
      if (model_q.size() == 0) chk("mem_wr_unexpected", {31'd0, mem_wr}, 32'd0);
      else chk("mem_order", {mem_addr, mem_write_data}, model_q[0]);
    end else begin
      chk("mem_idle_zero", {mem_addr, mem_write_data}, 32'd0);
    end
    e_hit = 1'b0;
    e_data = '0;
`ifdef WB_FORWARD_EN
    foreach (model_q[i]) if (model_q[i][31:16] == rd_addr) begin
      e_hit = 1'b1;
      e_data = model_q[i][15:0];
    end
`endif
    chk("fwd", {15'd0, rd_hit, rd_data}, {15'd0, e_hit, e_data});
    if (rst_n) begin
      if (mem_wr && !mem_busy && model_q.size() != 0) void'(model_q.pop_front());
      if (wr_req_valid && wr_req_ready) model_q.push_back({wr_req_addr, wr_req_data});
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem", {mem_addr, mem_write_data}, 32'd0);
    chk("rst_empty_ready", {30'd0, buf_empty, wr_req_ready}, 32'd3);
    tick(); tick();
    rst_n = 1'b1;

    // 1: single write, two-cycle latency, one-cycle mem_wr
    wr_req_valid = 1'b1; wr_req_addr = 16'h0010; wr_req_data = 16'hBEEF;
    tick();
    wr_req_valid = 1'b0;
    chk("t1_not_yet", {31'd0, mem_wr}, 32'd0);
    tick();
    chk("t1_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("t1_mem", {mem_addr, mem_write_data}, 32'h0010BEEF);
    tick();
    chk("t1_one_cycle", {31'd0, mem_wr}, 32'd0);
    chk("t1_empty", {31'd0, buf_empty}, 32'd1);

    // 2: fill_busy holds the drain, buffer fills, fifth write waits
    fill_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ent_a[k] = 16'h0100 + 16'(k);
      ent_d[k] = 16'($urandom);
    end
    for (int k = 0; k < 4; k++) begin
      wr_req_valid = 1'b1; wr_req_addr = ent_a[k]; wr_req_data = ent_d[k];
      tick();
    end
    wr_req_addr = ent_a[4]; wr_req_data = ent_d[4];
    chk("t2_full", {31'd0, wr_req_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_held", {30'd0, wr_req_ready, mem_wr}, 32'd0);
    end
    fill_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_b2b", {15'd0, mem_wr, mem_addr}, {15'd0, 1'b1, ent_a[k]});
      if (k == 1) chk("t2_ready_back", {31'd0, wr_req_ready}, 32'd1);
      if (k == 2) wr_req_valid = 1'b0;
    end
    wait_empty(20);

    // 3: memory stall holds the request stable
    mem_busy = 1'b1;
    wr_req_valid = 1'b1; wr_req_addr = 16'h0A5A; wr_req_data = 16'h1234;
    tick();
    wr_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_stall", {mem_addr, mem_write_data}, 32'h0A5A1234);
      chk("t3_stall_wr", {30'd0, mem_wr, buf_empty}, 32'd2);
    end
    mem_busy = 1'b0;
    tick();
    chk("t3_popped", {30'd0, mem_wr, buf_empty}, 32'd1);

    // 4: random traffic with wrap-around, reference queue checks order
    for (int c = 0; c < 120; c++) begin
      if (!wr_req_valid && $urandom_range(0, 3) != 0) begin
        wr_req_valid = 1'b1;
        wr_req_addr  = 16'h0020 + 16'($urandom_range(0, 7));
        wr_req_data  = 16'($urandom);
      end
      fill_busy = ($urandom_range(0, 5) == 0);
      mem_busy  = ($urandom_range(0, 3) == 0);
      rd_addr   = 16'h0020 + 16'($urandom_range(0, 7));
      acc = wr_req_valid && wr_req_ready;
      tick();
      if (acc) wr_req_valid = 1'b0;
    end
    wr_req_valid = 1'b0; fill_busy = 1'b0; mem_busy = 1'b0;
    wait_empty(40);

    // 5: asynchronous reset in the middle of ISSUE
    fill_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_req_valid = 1'b1; wr_req_addr = 16'h0300 + 16'(k); wr_req_data = 16'(k);
      tick();
    end
    wr_req_valid = 1'b0; fill_busy = 1'b0; mem_busy = 1'b1;
    tick();
    chk("t5_issue", {31'd0, mem_wr}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_wr", {31'd0, mem_wr}, 32'd0);
    chk("t5_async_mem", {mem_addr, mem_write_data}, 32'd0);
    chk("t5_async_flags", {30'd0, buf_empty, wr_req_ready}, 32'd3);
    mem_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_no_wr", {31'd0, mem_wr}, 32'd0);
    end

`ifdef WB_FORWARD_EN
    // 6: forwarding returns the newest matching entry
    fill_busy = 1'b1;
    wr_req_valid = 1'b1; wr_req_addr = 16'h0020; wr_req_data = 16'h1111;
    tick();
    wr_req_data = 16'h2222;
    tick();
    wr_req_valid = 1'b0;
    rd_addr = 16'h0020;
    #1;
    chk("t6_hit", {15'd0, rd_hit, rd_data}, {15'd0, 1'b1, 16'h2222});
    rd_addr = 16'h0030;
    #1;
    chk("t6_miss", {31'd0, rd_hit}, 32'd0);
    fill_busy = 1'b0;
    wait_empty(20);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
